// File: rtl/irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
//   Shared definitions for the interrupt controller: software register map
//   and the request/service state encoding.
// ---------------------------------------------------------------------------
package irq_pkg;

    // Register map (bus addr field).
    localparam logic [1:0] IRQ_ENABLE  = 2'd0;  // rw, one enable bit per source
    localparam logic [1:0] IRQ_PENDING = 2'd1;  // r, write-1-to-clear
    localparam logic [1:0] IRQ_STATUS  = 2'd2;  // r, {pad, busy, irq_id}
    localparam logic [1:0] IRQ_GIE     = 2'd3;  // rw, bit 0 global enable

    // Request handshake state.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// irq_ctrl_if
//   Groups the software register port and the core request handshake.
//   master : bus/core side (drives strobes, write data, ack/done)
//   slave  : interrupt controller (drives rdata, irq_req, irq_id)
//   Signals:
//     wr_en, rd_en  one-cycle register strobes
//     addr, wdata   register select / write data
//     rdata         read data, valid the cycle after rd_en
//     irq_req       request to core
//     irq_id        id of the requested / in-service source
//     irq_ack       core accepts the request (pulse)
//     irq_done      core finished the handler (pulse)
// ---------------------------------------------------------------------------
interface irq_ctrl_if #(
    parameter int ID_W = 2
);
    logic            wr_en;
    logic            rd_en;
    logic [1:0]      addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            irq_req;
    logic [ID_W-1:0] irq_id;
    logic            irq_ack;
    logic            irq_done;

    modport master (
        output wr_en, rd_en, addr, wdata, irq_ack, irq_done,
        input  rdata, irq_req, irq_id
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata, irq_ack, irq_done,
        output rdata, irq_req, irq_id
    );
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
//   Combinational fixed-priority encoder; index 0 has the highest priority.
//   Ports:
//     req    in  NUM_SRC  request vector
//     valid  out 1        at least one request set
//     id     out ID_W     index of the lowest set bit (0 when none)
// ---------------------------------------------------------------------------
module irq_prio_enc #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    // NOTE: every output of an always_comb gets a default before any branch,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        // Walk from the lowest-priority end so the last hit is the winner.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl
//   Interrupt controller: latches source lines into pending bits, masks them
//   with per-source enables and a global enable, picks the lowest eligible
//   index and runs a req/ack/done handshake with the core. One interrupt in
//   service at a time.
//   Ports:
//     clk      in   rising-edge clock
//     rst_n    in   asynchronous active-low reset
//     irq_src  in   raw interrupt lines (bit 0 = timer Counter int)
//     bus      slave modport of irq_ctrl_if (register port + handshake)
// ---------------------------------------------------------------------------
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC  = 4,
    parameter int ID_W     = 2,
    parameter int SRC_EDGE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    irq_ctrl_if.slave          bus
);

    logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
    logic [NUM_SRC-1:0] pending_q,  pending_d;
    logic [NUM_SRC-1:0] enable_q,   enable_d;
    logic               gie_q,      gie_d;
    irq_state_e         state_q,    state_d;
    logic [ID_W-1:0]    id_q,       id_d;
    logic [31:0]        rdata_q,    rdata_d;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] set_vec;
    logic [NUM_SRC-1:0] clr_vec;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic               wr_enable;
    logic               wr_pending;
    logic               wr_gie;
    logic               ack_take;
    logic               busy;
    logic               unused_wdata;

    assign wr_enable  = bus.wr_en && (bus.addr == IRQ_ENABLE);
    assign wr_pending = bus.wr_en && (bus.addr == IRQ_PENDING);
    assign wr_gie     = bus.wr_en && (bus.addr == IRQ_GIE);
    assign ack_take   = (state_q == REQ) && bus.irq_ack;
    assign busy       = (state_q == SERVICE);
    assign unused_wdata = ^bus.wdata[31:NUM_SRC];

    assign eligible = pending_q & enable_q & {NUM_SRC{gie_q}};

    // Level mode pends on every high cycle; edge mode only on a 0->1 step.
    assign set_vec = (SRC_EDGE != 0) ? (irq_src & ~src_prev_q) : irq_src;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (eligible),
        .valid (win_valid),
        .id    (win_id)
    );

    // Pending/enable/gie next state. Set is OR-ed in after the clear so a
    // source firing in the same cycle as a W1C or an ack stays pending.
    always_comb begin
        clr_vec = '0;
        if (wr_pending) begin
            clr_vec = bus.wdata[NUM_SRC-1:0];
        end
        if (ack_take) begin
            clr_vec[id_q] = 1'b1;
        end
        pending_d  = (pending_q & ~clr_vec) | set_vec;
        enable_d   = wr_enable ? bus.wdata[NUM_SRC-1:0] : enable_q;
        gie_d      = wr_gie ? bus.wdata[0] : gie_q;
        src_prev_d = irq_src;
    end

    // Handshake FSM. The id is latched on entry to REQ and frozen until the
    // controller returns to IDLE, so a later higher-priority source waits.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = REQ;
                    id_d    = win_id;
                end
            end
            REQ: begin
                // Ack takes precedence over a simultaneous loss of eligibility.
                if (bus.irq_ack) begin
                    state_d = SERVICE;
                end else if (!eligible[id_q]) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (bus.irq_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data is captured only on rd_en and held otherwise.
    always_comb begin
        rdata_d = rdata_q;
        if (bus.rd_en) begin
            case (bus.addr)
                IRQ_ENABLE:  rdata_d = 32'(enable_q);
                IRQ_PENDING: rdata_d = 32'(pending_q);
                IRQ_STATUS:  rdata_d = 32'({busy, id_q});
                IRQ_GIE:     rdata_d = 32'(gie_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev_q <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            gie_q      <= 1'b0;
            state_q    <= IDLE;
            id_q       <= '0;
            rdata_q    <= '0;
        end else begin
            src_prev_q <= src_prev_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            gie_q      <= gie_d;
            state_q    <= state_d;
            id_q       <= id_d;
            rdata_q    <= rdata_d;
        end
    end

    // irq_req is a pure function of state, so reset drops it immediately and
    // there is no combinational path from irq_ack.
    assign bus.irq_req = (state_q == REQ);
    assign bus.irq_id  = id_q;
    assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl
//   Two controllers share stimulus: u_dut_lvl (level pending) and
//   u_dut_edge (edge pending). A behavioural model per instance predicts
//   irq_req, irq_id and rdata; a negedge process compares every cycle.
//   Directed sequences add literal expectations, then random traffic runs.
// ---------------------------------------------------------------------------
module tb_irq_ctrl;
    import irq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  irq_src;
    logic        wr_en;
    logic        rd_en;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  ack;
    logic [1:0]  done;

    int n_checks = 0;
    int n_fail   = 0;

    irq_ctrl_if #(.ID_W(2)) bus0 ();
    irq_ctrl_if #(.ID_W(2)) bus1 ();

    assign bus0.wr_en    = wr_en;
    assign bus0.rd_en    = rd_en;
    assign bus0.addr     = addr;
    assign bus0.wdata    = wdata;
    assign bus0.irq_ack  = ack[0];
    assign bus0.irq_done = done[0];
    assign bus1.wr_en    = wr_en;
    assign bus1.rd_en    = rd_en;
    assign bus1.addr     = addr;
    assign bus1.wdata    = wdata;
    assign bus1.irq_ack  = ack[1];
    assign bus1.irq_done = done[1];

    irq_ctrl #(.NUM_SRC(4), .ID_W(2), .SRC_EDGE(0)) u_dut_lvl (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_src (irq_src),
        .bus     (bus0)
    );

    irq_ctrl #(.NUM_SRC(4), .ID_W(2), .SRC_EDGE(1)) u_dut_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_src (irq_src),
        .bus     (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 requesting, 2 in service.
    logic [3:0]  m_pend[2];
    logic [3:0]  m_en[2];
    logic [3:0]  m_prev[2];
    logic        m_gie[2];
    int          m_phase[2];
    logic [1:0]  m_id[2];
    logic [31:0] m_rdata[2];

    task automatic model_step(input int k);
        logic [3:0] elig;
        logic [3:0] set_v;
        logic [3:0] clr_v;
        int         win;
        int         nxt;
        elig = m_gie[k] ? (m_pend[k] & m_en[k]) : 4'b0000;
        if (rd_en) begin
            case (addr)
                2'd0:    m_rdata[k] = {28'd0, m_en[k]};
                2'd1:    m_rdata[k] = {28'd0, m_pend[k]};
                2'd2:    m_rdata[k] = {29'd0, (m_phase[k] == 2), m_id[k]};
                default: m_rdata[k] = {31'd0, m_gie[k]};
            endcase
        end
        set_v = (k == 1) ? (irq_src & ~m_prev[k]) : irq_src;
        clr_v = 4'b0000;
        if (wr_en && addr == 2'd1) clr_v = wdata[3:0];
        if (ack[k] && m_phase[k] == 1) clr_v[m_id[k]] = 1'b1;
        nxt = m_phase[k];
        if (m_phase[k] == 0 && elig != 4'b0000) begin
            win = 0;
            for (int i = 3; i >= 0; i--) if (elig[i]) win = i;
            m_id[k] = 2'(win);
            nxt = 1;
        end else if (m_phase[k] == 1) begin
            if (ack[k]) nxt = 2;
            else if (!elig[m_id[k]]) nxt = 0;
        end else if (m_phase[k] == 2 && done[k]) begin
            nxt = 0;
        end
        m_phase[k] = nxt;
        m_pend[k]  = (m_pend[k] & ~clr_v) | set_v;
        if (wr_en && addr == 2'd0) m_en[k] = wdata[3:0];
        if (wr_en && addr == 2'd3) m_gie[k] = wdata[0];
        m_prev[k] = irq_src;
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_pend[k]  = '0;
                m_en[k]    = '0;
                m_prev[k]  = '0;
                m_gie[k]   = 1'b0;
                m_phase[k] = 0;
                m_id[k]    = '0;
                m_rdata[k] = '0;
            end else begin
                model_step(k);
            end
        end
    end

    // Continuous comparison, away from the active edge.
    always @(negedge clk) begin
        check("req_lvl", 32'(bus0.irq_req), 32'(m_phase[0] == 1));
        check("req_edge", 32'(bus1.irq_req), 32'(m_phase[1] == 1));
        if (m_phase[0] != 0) check("id_lvl", 32'(bus0.irq_id), 32'(m_id[0]));
        if (m_phase[1] != 0) check("id_edge", 32'(bus1.irq_id), 32'(m_id[1]));
        check("rdata_lvl", bus0.rdata, m_rdata[0]);
        check("rdata_edge", bus1.rdata, m_rdata[1]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        wr_en = 1'b1;
        addr  = a;
        wdata = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        rd_en = 1'b1;
        addr  = a;
        cyc();
        rd_en = 1'b0;
        d = bus0.rdata;
    endtask

    task automatic pulse_src(input logic [3:0] s);
        irq_src = s;
        cyc();
        irq_src = 4'b0000;
    endtask

    task automatic ack_pulse();
        ack = 2'b11;
        cyc();
        ack = 2'b00;
    endtask

    task automatic done_pulse();
        done = 2'b11;
        cyc();
        done = 2'b00;
    endtask

    logic [31:0] rd;
    int          cnt[2];
    logic [1:0]  prev_req;
    logic [1:0]  prev_ack;
    logic [1:0]  req_now;

    initial begin
        rst_n = 1'b0; irq_src = '0; wr_en = 1'b0; rd_en = 1'b0;
        addr = '0; wdata = '0; ack = '0; done = '0;
        repeat (3) cyc();
        check("rst_req", 32'(bus0.irq_req), 32'd0);
        check("rst_rdata", bus0.rdata, 32'd0);
        rst_n = 1'b1;
        cyc();

        // 1: basic request / ack / done with latency t+2.
        bus_write(IRQ_GIE, 32'd1);
        bus_write(IRQ_ENABLE, 32'h1);
        pulse_src(4'b0001);
        check("t1_no_early_req", 32'(bus0.irq_req), 32'd0);
        cyc();
        check("t1_req", 32'(bus0.irq_req), 32'd1);
        check("t1_id", 32'(bus0.irq_id), 32'd0);
        ack_pulse();
        check("t1_req_after_ack", 32'(bus0.irq_req), 32'd0);
        bus_read(IRQ_PENDING, rd);
        check("t1_pending", rd, 32'h0);
        bus_read(IRQ_STATUS, rd);
        check("t1_status_busy", rd, 32'h4);
        done_pulse();
        bus_read(IRQ_STATUS, rd);
        check("t1_status_idle", rd, 32'h0);

        // 2: simultaneous sources, priority order.
        bus_write(IRQ_ENABLE, 32'hF);
        pulse_src(4'b1010);
        cyc();
        check("t2_req", 32'(bus0.irq_req), 32'd1);
        check("t2_id_first", 32'(bus0.irq_id), 32'd1);
        ack_pulse();
        done_pulse();
        check("t2_idle_after_done", 32'(bus0.irq_req), 32'd0);
        cyc();
        check("t2_req_second", 32'(bus0.irq_req), 32'd1);
        check("t2_id_second", 32'(bus0.irq_id), 32'd3);
        ack_pulse();
        done_pulse();

        // 3: no preemption of the latched id.
        pulse_src(4'b0100);
        cyc();
        check("t3_id2", 32'(bus0.irq_id), 32'd2);
        pulse_src(4'b0001);
        cyc();
        check("t3_req_held", 32'(bus0.irq_req), 32'd1);
        check("t3_id_frozen", 32'(bus0.irq_id), 32'd2);
        ack_pulse();
        done_pulse();
        cyc();
        check("t3_req_id0", 32'(bus0.irq_req), 32'd1);
        check("t3_id0", 32'(bus0.irq_id), 32'd0);
        ack_pulse();
        done_pulse();

        // 4: masking withdraws the request, re-enable restores it.
        bus_write(IRQ_ENABLE, 32'h1);
        pulse_src(4'b0001);
        cyc();
        check("t4_req", 32'(bus0.irq_req), 32'd1);
        bus_write(IRQ_ENABLE, 32'h0);
        cyc();
        check("t4_req_dropped", 32'(bus0.irq_req), 32'd0);
        bus_read(IRQ_PENDING, rd);
        check("t4_pending_kept", rd, 32'h1);
        bus_write(IRQ_ENABLE, 32'h1);
        cyc();
        check("t4_req_back", 32'(bus0.irq_req), 32'd1);
        ack_pulse();
        done_pulse();

        // 5: set wins over W1C and over ack.
        bus_write(IRQ_ENABLE, 32'h0);
        irq_src = 4'b0001; wr_en = 1'b1; addr = IRQ_PENDING; wdata = 32'h1;
        cyc();
        irq_src = 4'b0000; wr_en = 1'b0;
        bus_read(IRQ_PENDING, rd);
        check("t5_set_beats_w1c", rd, 32'h1);
        bus_write(IRQ_PENDING, 32'h1);
        bus_read(IRQ_PENDING, rd);
        check("t5_w1c_clears", rd, 32'h0);
        bus_write(IRQ_ENABLE, 32'h1);
        pulse_src(4'b0001);
        cyc();
        check("t5_req", 32'(bus0.irq_req), 32'd1);
        ack = 2'b11; irq_src = 4'b0001;
        cyc();
        ack = 2'b00; irq_src = 4'b0000;
        bus_read(IRQ_PENDING, rd);
        check("t5_set_beats_ack", rd, 32'h1);
        done_pulse();
        cyc();
        check("t5_rereq", 32'(bus0.irq_req), 32'd1);
        ack_pulse();
        done_pulse();

        // 6: held-high source, level vs edge, core auto-responds.
        cnt[0] = 0; cnt[1] = 0; prev_req = '0; prev_ack = '0;
        for (int i = 0; i < 16; i++) begin
            req_now = {bus1.irq_req, bus0.irq_req};
            for (int k = 0; k < 2; k++) if (req_now[k] && !prev_req[k]) cnt[k]++;
            irq_src  = (i < 10) ? 4'b0001 : 4'b0000;
            done     = prev_ack;
            ack      = req_now;
            prev_ack = req_now;
            prev_req = req_now;
            cyc();
        end
        ack = '0; done = '0;
        check("t6_edge_one_req", 32'(cnt[1]), 32'd1);
        check("t6_level_rereq", 32'(cnt[0] >= 3), 32'd1);

        // Asynchronous reset mid-handshake.
        pulse_src(4'b0001);
        cyc();
        check("t6_req_before_rst", 32'(bus0.irq_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_req_async_lvl", 32'(bus0.irq_req), 32'd0);
        check("t6_req_async_edge", 32'(bus1.irq_req), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            check("t6_reg_after_rst", rd, 32'h0);
        end

        // Random traffic against the model.
        bus_write(IRQ_GIE, 32'd1);
        bus_write(IRQ_ENABLE, 32'hF);
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 4; b++) irq_src[b] = ($urandom_range(0, 5) == 0);
            wr_en = ($urandom_range(0, 9) == 0);
            addr  = 2'($urandom_range(0, 3));
            wdata = $urandom;
            if (addr == IRQ_GIE) wdata[0] = ($urandom_range(0, 3) != 0);
            rd_en   = ($urandom_range(0, 2) == 0);
            ack[0]  = ($urandom_range(0, 2) == 0);
            ack[1]  = ($urandom_range(0, 2) == 0);
            done[0] = ($urandom_range(0, 3) == 0);
            done[1] = ($urandom_range(0, 3) == 0);
            cyc();
        end
        irq_src = '0; wr_en = 1'b0; rd_en = 1'b0; ack = '0; done = '0;
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
